fft_mag_arbiter: RTL
====================

# fft_mag_arbiter

Shares the single 45-bit pipelined square-root unit between the red and IR FFT output streams of the pulse-ox datapath. The block accepts complex FFT bins from both channels, forms re²+im², issues one radicand per cycle to the sqrt unit, and re-attaches channel and bin tags to each returned root. Tagged magnitudes then go to the per-channel sorting/peak logic.

## Interface
- FFT_LEN, 1024: bins per frame, power of two.
- TAG_DEPTH, 32: tag FIFO entries. Must be ≥ sqrt latency + 3.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- red_valid / ir_valid  in  1  FFT bin present on the channel.
- red_sop / ir_sop  in  1  with valid: bin is bin 0 of a new frame.
- red_data / ir_data  in  36  [35:18] signed real, [17:0] signed imaginary.
- red_ready / ir_ready  out  1  bin accepted this cycle when valid&ready.
- sqrt_start  out  1  radicand valid, to sqrt unit.
- sqrt_radicand  out  45  unsigned re²+im².
- sqrt_valid  in  1  root valid, from sqrt unit.
- sqrt_root  in  23  unsigned root.
- mag_valid  out  1  tagged magnitude valid, single-cycle.
- mag_data  out  24  root, zero-extended.
- mag_chan  out  1  0 = red, 1 = IR.
- mag_bin  out  10  bin index.
- mag_last  out  1  final forwarded bin of a frame.
- tag_err  out  1  sticky: sqrt_valid arrived with the tag FIFO empty.

## Operation
- Arbitration: at most one accept per cycle.
  - If only one channel is valid, that channel gets ready.
  - If both are valid, round-robin: the channel not granted last wins. After reset, red wins first.
  - ready is combinational from valid, the last-grant register and FIFO occupancy.
  - Both ready outputs are low when occupancy + in-flight ≥ TAG_DEPTH − 3.
- Bin counters: one 10-bit counter per channel.
  - Each accepted bin takes the counter value, then the counter increments and wraps at FFT_LEN−1 → 0.
  - An accepted bin with sop is tagged bin 0 and sets the counter to 1, even mid-frame.
- Arithmetic:
  - Stage 1 registers the signed 18×18 products re² and im² (36 bits each).
  - Stage 2 registers their unsigned sum (37 bits), zero-extended to 45 bits, together with sqrt_start.
  - Maximum radicand is 2³⁵ (both components −131072); no overflow is possible.
- Tags: when sqrt_start is high, {chan, bin, last} is pushed into the FIFO. Each sqrt_valid pops one entry.
- Output: mag_* is registered from sqrt_root and the popped tag.
  - If sqrt_valid arrives with the FIFO empty: tag_err is set, mag_valid stays low and nothing is popped.
- last = bin equals the final forwarded bin (FFT_LEN/2−1 or FFT_LEN−1, see Configuration).
- Reset, asynchronous and applicable mid-operation:
  - Clears the pipeline, FIFO, counters, last-grant and tag_err.
  - All outputs go to 0; ready goes to 0 while reset is asserted.
  - Results returned by the sqrt unit after reset for pre-reset issues set tag_err. The sqrt unit shares reset_n, so this does not happen in a correct system.

## Timing
- Accept in cycle N → sqrt_start in cycle N+2.
- sqrt_valid in cycle M → mag_valid in cycle M+1.
- The nominal sqrt unit has 24-cycle latency, giving accept → mag_valid = 27 cycles.
- The block is latency-agnostic: tags are matched in FIFO order.
- Throughput is one bin per cycle total, split between channels. There is no downstream backpressure, so mag_valid cannot be stalled.
- Simultaneous FIFO push and pop in the same cycle is legal and leaves occupancy unchanged.

## Configuration
- MAG_HALF_SPECTRUM_EN defined:
  - Bins ≥ FFT_LEN/2 are accepted (ready behaves normally) and counted, but not issued to the sqrt unit, so they produce no tag and no output.
  - mag_last is set on bin FFT_LEN/2−1.
- MAG_HALF_SPECTRUM_EN undefined: every bin is issued and mag_last is set on bin FFT_LEN−1.

## Test plan
- Single bin, red only, with sop, data re=3, im=4:
  - red_ready=1 in the same cycle.
  - sqrt_radicand=25 two cycles later.
  - mag_valid with mag_data=5, mag_chan=0, mag_bin=0, 27 cycles after accept.
- Extreme input, IR, re=−131072, im=−131072 → radicand 2³⁵, mag_data=185363.
- Both channels valid continuously for 8 cycles → grants alternate R,I,R,I,…; outputs carry bins 0–3 for each channel in grant order.
- MAG_HALF_SPECTRUM_EN defined, red streams 1024 bins with sop on the first:
  - 1024 accepts and exactly 512 mag_valid pulses.
  - mag_last only on bin 511.
  - Undefined: 1024 outputs, last on bin 1023.
- Red sop asserted at counter value 700 → that bin is tagged 0 and the next bin is tagged 1.
- Reset asserted mid-stream with 10 bins in flight, sqrt unit reset simultaneously:
  - All outputs are 0 immediately.
  - After release, the first accepted red bin is tagged 0, the first grant goes to red, and tag_err stays 0.

Source files
------------

// File: rtl/fft_mag_arbiter.sv
// fft_mag_arbiter
//
// Shares one pipelined square-root unit between the red and IR FFT output
// streams. Each accepted complex bin is squared and summed (re^2 + im^2) over
// two registered stages. The result is then issued to the sqrt unit, and a
// {chan, bin, last} tag is queued. Every root that comes back pops one tag,
// so the unit may have any latency as long as it returns results in order.
//
// Optional feature macro: MAG_HALF_SPECTRUM_EN
//   defined   - bins >= FFT_LEN/2 are accepted and counted but never issued;
//               mag_last marks bin FFT_LEN/2-1.
//   undefined - every bin is issued; mag_last marks bin FFT_LEN-1.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   red_valid/sop/data     red FFT bin: data[35:18] signed re, [17:0] signed im
//   ir_valid/sop/data      IR FFT bin, same format
//   red_ready, ir_ready    combinational accept strobes (valid & ready)
//   sqrt_start             radicand valid to the sqrt unit
//   sqrt_radicand          45-bit unsigned re^2 + im^2
//   sqrt_valid, sqrt_root  returned root from the sqrt unit
//   mag_valid              single-cycle tagged magnitude strobe
//   mag_data               root, zero-extended to 24 bits
//   mag_chan               0 = red, 1 = IR
//   mag_bin                bin index of the magnitude
//   mag_last               final forwarded bin of a frame
//   tag_err                sticky: a root arrived while no tag was queued

module fft_mag_arbiter #(
  parameter int unsigned FFT_LEN   = 1024,
  parameter int unsigned TAG_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        red_valid,
  input  logic        red_sop,
  input  logic [35:0] red_data,
  output logic        red_ready,

  input  logic        ir_valid,
  input  logic        ir_sop,
  input  logic [35:0] ir_data,
  output logic        ir_ready,

  output logic        sqrt_start,
  output logic [44:0] sqrt_radicand,
  input  logic        sqrt_valid,
  input  logic [22:0] sqrt_root,

  output logic        mag_valid,
  output logic [23:0] mag_data,
  output logic        mag_chan,
  output logic [9:0]  mag_bin,
  output logic        mag_last,
  output logic        tag_err
);

  localparam int unsigned BinW = 10;
  // Tag layout: {chan, bin, last}
  localparam int unsigned TagW = BinW + 2;
  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  // One spare bit so occupancy plus the two in-flight stages never wraps.
  localparam int unsigned LvlW = $clog2(TAG_DEPTH + 1) + 1;

  localparam logic [BinW-1:0] BinOne  = BinW'(1);
  localparam logic [BinW-1:0] BinMax  = BinW'(FFT_LEN - 1);
`ifdef MAG_HALF_SPECTRUM_EN
  localparam logic [BinW-1:0] HalfLen = BinW'(FFT_LEN / 2);
  localparam logic [BinW-1:0] LastBin = BinW'(FFT_LEN / 2 - 1);
`else
  localparam logic [BinW-1:0] LastBin = BinMax;
`endif
  localparam logic [LvlW-1:0] LvlOne  = LvlW'(1);
  localparam logic [LvlW-1:0] StopLvl = LvlW'(TAG_DEPTH - 3);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(TAG_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                   last_ir_q;   // 1 when IR was the most recent grant
  logic [BinW-1:0]        red_cnt_q, red_cnt_d;
  logic [BinW-1:0]        ir_cnt_q, ir_cnt_d;

  logic                   s1_valid_q;
  logic [35:0]            s1_re_sq_q, s1_im_sq_q;
  logic [TagW-1:0]        s1_tag_q;

  logic                   s2_valid_q;
  logic [36:0]            s2_sum_q;
  logic [TagW-1:0]        s2_tag_q;

  logic [TagW-1:0]        tag_mem [TAG_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]        occ_q, occ_d;

  logic                   mag_valid_q;
  logic [23:0]            mag_data_q;
  logic                   mag_chan_q;
  logic [BinW-1:0]        mag_bin_q;
  logic                   mag_last_q;
  logic                   tag_err_q;

  // ---------------------------------------------------------------------------
  // Arbitration and flow control
  // ---------------------------------------------------------------------------
  logic [LvlW-1:0] level;
  logic            room;
  logic            grant_red, grant_ir;

  always_comb begin
    // Entries in stages 1 and 2 will each claim a tag slot, so count them now.
    level     = occ_q + LvlW'(s1_valid_q) + LvlW'(s2_valid_q);
    // Ready is forced low while reset is held, not just after the next edge.
    room      = reset_n && (level < StopLvl);
    grant_red = red_valid && (!ir_valid || last_ir_q);
    grant_ir  = ir_valid && (!red_valid || !last_ir_q);
  end

  assign red_ready = room & grant_red;
  assign ir_ready  = room & grant_ir;

  // ---------------------------------------------------------------------------
  // Accept, bin tagging and squaring
  // ---------------------------------------------------------------------------
  logic               acc_red, acc_ir, acc_any, acc_issue;
  logic               acc_sop;
  logic [35:0]        acc_data;
  logic [BinW-1:0]    cur_cnt, next_cnt, acc_bin;
  logic signed [17:0] acc_re, acc_im;
  logic signed [35:0] re_ext, im_ext, re_sq, im_sq;

  always_comb begin
    acc_red  = red_valid & red_ready;
    acc_ir   = ir_valid & ir_ready;
    acc_any  = acc_red | acc_ir;

    acc_sop  = acc_ir ? ir_sop : red_sop;
    acc_data = acc_ir ? ir_data : red_data;
    cur_cnt  = acc_ir ? ir_cnt_q : red_cnt_q;

    // sop restarts the frame even mid-count: this bin is 0, the next is 1.
    acc_bin  = acc_sop ? '0 : cur_cnt;
    if (acc_sop) begin
      next_cnt = BinOne;
    end else if (cur_cnt == BinMax) begin
      next_cnt = '0;
    end else begin
      next_cnt = cur_cnt + BinOne;
    end

    red_cnt_d = acc_red ? next_cnt : red_cnt_q;
    ir_cnt_d  = acc_ir ? next_cnt : ir_cnt_q;

`ifdef MAG_HALF_SPECTRUM_EN
    // Upper-half bins are counted but produce no radicand, tag or output.
    acc_issue = acc_any && (acc_bin < HalfLen);
`else
    acc_issue = acc_any;
`endif

    acc_re = acc_data[35:18];
    acc_im = acc_data[17:0];
    // Widen before multiplying so the full signed 36-bit product is kept.
    re_ext = 36'(acc_re);
    im_ext = 36'(acc_im);
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ir_q <= 1'b1;  // makes red the first winner of a tie
      red_cnt_q <= '0;
      ir_cnt_q  <= '0;
    end else begin
      if (acc_any) begin
        last_ir_q <= acc_ir;
      end
      red_cnt_q <= red_cnt_d;
      ir_cnt_q  <= ir_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: squares; stage 2: sum driven straight to the sqrt unit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_re_sq_q <= '0;
      s1_im_sq_q <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= acc_issue;
      if (acc_issue) begin
        // Squares are never negative, so they can be kept as unsigned.
        s1_re_sq_q <= re_sq;
        s1_im_sq_q <= im_sq;
        s1_tag_q   <= {acc_ir, acc_bin, (acc_bin == LastBin)};
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        // Largest sum is 2^35, so 37 bits cannot overflow.
        s2_sum_q <= {1'b0, s1_re_sq_q} + {1'b0, s1_im_sq_q};
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign sqrt_start    = s2_valid_q;
  assign sqrt_radicand = {8'b0, s2_sum_q};

  // ---------------------------------------------------------------------------
  // Tag FIFO: pushed on issue, popped on every returned root
  // ---------------------------------------------------------------------------
  logic            push, pop, underflow;
  logic [TagW-1:0] rd_tag;

  always_comb begin
    push      = s2_valid_q;
    pop       = sqrt_valid && (occ_q != '0);
    underflow = sqrt_valid && (occ_q == '0);
    case ({push, pop})
      2'b10:   occ_d = occ_q + LvlOne;
      2'b01:   occ_d = occ_q - LvlOne;
      default: occ_d = occ_q;
    endcase
  end

  assign rd_tag = tag_mem[rd_ptr_q];

  // Storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= s2_tag_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrOne;
      end
      occ_q <= occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tagged magnitude output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_valid_q <= 1'b0;
      mag_data_q  <= '0;
      mag_chan_q  <= 1'b0;
      mag_bin_q   <= '0;
      mag_last_q  <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      mag_valid_q <= pop;
      if (pop) begin
        mag_data_q <= {1'b0, sqrt_root};
        mag_chan_q <= rd_tag[TagW-1];
        mag_bin_q  <= rd_tag[TagW-2:1];
        mag_last_q <= rd_tag[0];
      end
      // A root with no queued tag is dropped and flagged until reset.
      if (underflow) begin
        tag_err_q <= 1'b1;
      end
    end
  end

  assign mag_valid = mag_valid_q;
  assign mag_data  = mag_data_q;
  assign mag_chan  = mag_chan_q;
  assign mag_bin   = mag_bin_q;
  assign mag_last  = mag_last_q;
  assign tag_err   = tag_err_q;

endmodule
